// File: rtl/tick_period_meter.sv
// tick_period_meter: measures the clk-cycle spacing between rising edges of a
// tick/enable stream, flags whether each period is within TOL of EXPECT, and
// raises a sticky timeout when ticks stop arriving for MAX_COUNT cycles.
//
// Output handshake: period_valid is a one-cycle strobe with no back-pressure.
// period and in_range are updated in the same cycle the strobe is high and
// hold their values until the next strobe or a reset. A consumer must take
// the value while period_valid is high; there is no ready input.
module tick_period_meter #(
  parameter int W         = 25,
  parameter int MAX_COUNT = 33554431,
  parameter int EXPECT    = 27000001,
  parameter int TOL       = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sys_reset,
  input  logic         enable,
  input  logic         tick,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         in_range,
  output logic         timeout,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  localparam int WE = W + 1;
  localparam logic [W-1:0] MAX_W = W'(MAX_COUNT);
  // One extra bit so the deviation subtraction never overflows either way.
  localparam logic [W:0]   EXP_E = WE'(EXPECT);
  localparam logic [W:0]   TOL_E = WE'(TOL);

  state_t       r_state;
  state_t       w_state_nx;
  logic [W-1:0] r_count;
  logic [W-1:0] w_count_nx;
  logic [W-1:0] r_period;
  logic [W-1:0] w_period_nx;
  logic         r_period_valid;
  logic         w_valid_nx;
  logic         r_in_range;
  logic         w_in_range_nx;
  logic         r_timeout;
  logic         w_timeout_nx;
  logic         r_tick_d;

  logic         w_rst;
  logic         w_edge;
  logic [W:0]   w_count_e;
  logic [W:0]   w_dev;
  logic         w_in_tol;

  assign w_rst     = reset | sys_reset;
  assign w_edge    = tick & ~r_tick_d;
  assign w_count_e = {1'b0, r_count};
  assign w_dev     = (w_count_e >= EXP_E) ? (w_count_e - EXP_E) : (EXP_E - w_count_e);
  assign w_in_tol  = (w_dev <= TOL_E);

  // State register.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and datapath next values; measurement priority in MEASURE is
  // enable drop, then edge, then timeout, then plain counting.
  always_comb begin
    w_state_nx    = r_state;
    w_count_nx    = r_count;
    w_period_nx   = r_period;
    w_valid_nx    = 1'b0;
    w_in_range_nx = r_in_range;
    w_timeout_nx  = r_timeout;
    case (r_state)
      S_IDLE: begin
        w_count_nx = '0;
        if (enable) begin
          w_state_nx = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!enable) begin
          w_state_nx = S_IDLE;
          w_count_nx = '0;
        end else if (w_edge) begin
          // The arming edge only starts the count; it never reports a period.
          w_state_nx = S_MEASURE;
          w_count_nx = W'(1);
        end
      end
      S_MEASURE: begin
        if (!enable) begin
          w_state_nx = S_IDLE;
          w_count_nx = '0;
        end else if (w_edge) begin
          w_period_nx   = r_count;
          w_valid_nx    = 1'b1;
          w_in_range_nx = w_in_tol;
          w_timeout_nx  = 1'b0;
          w_count_nx    = W'(1);
        end else if (r_count == MAX_W) begin
          // Counter stops here, so it can never wrap.
          w_timeout_nx = 1'b1;
          w_count_nx   = '0;
          w_state_nx   = S_ARMED;
        end else begin
          w_count_nx = r_count + W'(1);
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_count_nx = '0;
      end
    endcase
  end

  // Datapath registers; tick_d resets high so a tick held across reset
  // release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_count        <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_in_range     <= 1'b0;
      r_timeout      <= 1'b0;
      r_tick_d       <= 1'b1;
    end else begin
      r_count        <= w_count_nx;
      r_period       <= w_period_nx;
      r_period_valid <= w_valid_nx;
      r_in_range     <= w_in_range_nx;
      r_timeout      <= w_timeout_nx;
      r_tick_d       <= tick;
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign in_range     = r_in_range;
  assign timeout      = r_timeout;
  assign busy         = (r_state == S_ARMED) || (r_state == S_MEASURE);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter with W=8, MAX_COUNT=20, EXPECT=4.
// dut0 uses TOL=0 and dut1 uses TOL=1; both share the same stimulus.
module tb_tick_period_meter;

  localparam int W = 8;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  logic         clk = 1'b0;
  logic         reset;
  logic         sys_reset;
  logic         enable;
  logic         tick;

  logic [W-1:0] period0, period1;
  logic         valid0, valid1;
  logic         inr0, inr1;
  logic         to0, to1;
  logic         busy0, busy1;
  logic [1:0]   st0, st1;

  int checks = 0;
  int errors = 0;

  // Clock: 10 time-unit period; inputs change and outputs are sampled on negedge.
  always #5 clk = ~clk;

  tick_period_meter #(.W(W), .MAX_COUNT(20), .EXPECT(4), .TOL(0)) dut0 (
    .clk(clk), .reset(reset), .sys_reset(sys_reset), .enable(enable), .tick(tick),
    .period(period0), .period_valid(valid0), .in_range(inr0), .timeout(to0),
    .busy(busy0), .dbg_state(st0)
  );

  tick_period_meter #(.W(W), .MAX_COUNT(20), .EXPECT(4), .TOL(1)) dut1 (
    .clk(clk), .reset(reset), .sys_reset(sys_reset), .enable(enable), .tick(tick),
    .period(period1), .period_valid(valid1), .in_range(inr1), .timeout(to1),
    .busy(busy1), .dbg_state(st1)
  );

  // Drive tick for one clock and return at the following negedge.
  task automatic cyc(input logic t);
    tick = t;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A completed measurement on both instances.
  task automatic chk_meas(input string tag, input int per, input logic r0, input logic r1);
    chk({tag, ".valid0"}, 32'(valid0), 32'd1);
    chk({tag, ".period0"}, 32'(period0), 32'(per));
    chk({tag, ".in_range0"}, 32'(inr0), 32'(r0));
    chk({tag, ".timeout0"}, 32'(to0), 32'd0);
    chk({tag, ".valid1"}, 32'(valid1), 32'd1);
    chk({tag, ".period1"}, 32'(period1), 32'(per));
    chk({tag, ".in_range1"}, 32'(inr1), 32'(r1));
  endtask

  // Reset-state outputs of dut0.
  task automatic chk_reset(input string tag);
    chk({tag, ".period"}, 32'(period0), 32'd0);
    chk({tag, ".valid"}, 32'(valid0), 32'd0);
    chk({tag, ".in_range"}, 32'(inr0), 32'd0);
    chk({tag, ".timeout"}, 32'(to0), 32'd0);
    chk({tag, ".busy"}, 32'(busy0), 32'd0);
    chk({tag, ".state"}, 32'(st0), 32'(ST_IDLE));
  endtask

  initial begin
    reset = 1'b1; sys_reset = 1'b0; enable = 1'b0; tick = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    chk_reset("reset");

    // Enable and arm.
    reset = 1'b0;
    cyc(1'b0);
    chk("idle_no_enable", 32'(st0), 32'(ST_IDLE));
    enable = 1'b1;
    cyc(1'b0);
    chk("armed.state", 32'(st0), 32'(ST_ARMED));
    chk("armed.busy", 32'(busy0), 32'd1);

    // First edge only arms; next edges every 4 cycles give period 4.
    cyc(1'b1);
    chk("first_edge.valid", 32'(valid0), 32'd0);
    chk("first_edge.state", 32'(st0), 32'(ST_MEASURE));
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    chk_meas("p4a", 4, 1'b1, 1'b1);
    cyc(1'b0);
    chk("strobe_one_cycle", 32'(valid0), 32'd0);
    chk("period_holds", 32'(period0), 32'd4);
    repeat (2) cyc(1'b0);
    cyc(1'b1);
    chk_meas("p4b", 4, 1'b1, 1'b1);

    // Intervals 5 then 3: out of range at TOL=0, in range at TOL=1.
    repeat (4) cyc(1'b0);
    cyc(1'b1);
    chk_meas("p5", 5, 1'b0, 1'b1);
    repeat (2) cyc(1'b0);
    cyc(1'b1);
    chk_meas("p3", 3, 1'b0, 1'b1);

    // Ticks stop: timeout after 20 edge-free cycles, back to ARMED.
    repeat (19) cyc(1'b0);
    chk("pre_timeout.timeout", 32'(to0), 32'd0);
    chk("pre_timeout.state", 32'(st0), 32'(ST_MEASURE));
    cyc(1'b0);
    chk("timeout.timeout0", 32'(to0), 32'd1);
    chk("timeout.timeout1", 32'(to1), 32'd1);
    chk("timeout.state", 32'(st0), 32'(ST_ARMED));
    chk("timeout.busy", 32'(busy0), 32'd1);
    chk("timeout.valid", 32'(valid0), 32'd0);
    chk("timeout.period_holds", 32'(period0), 32'd3);
    cyc(1'b1);
    chk("rearm.valid", 32'(valid0), 32'd0);
    chk("rearm.timeout_sticky", 32'(to0), 32'd1);
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    chk_meas("after_timeout", 4, 1'b1, 1'b1);

    // Tick held 3 high / 3 low: one event per high run, period 6.
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1);
      chk("held1.valid", 32'(valid0), 32'd0);
      cyc(1'b1);
      chk("held2.valid", 32'(valid0), 32'd0);
      repeat (3) cyc(1'b0);
      cyc(1'b1);
      chk_meas("p6", 6, 1'b0, 1'b0);
    end

    // Edge on the same cycle count reaches MAX_COUNT: edge wins.
    repeat (19) cyc(1'b0);
    cyc(1'b1);
    chk_meas("p20_max", 20, 1'b0, 1'b0);
    chk("p20_max.state", 32'(st0), 32'(ST_MEASURE));

    // Enable dropped on an edge cycle: no valid, straight to IDLE.
    repeat (3) cyc(1'b0);
    enable = 1'b0;
    cyc(1'b1);
    chk("en_drop.valid", 32'(valid0), 32'd0);
    chk("en_drop.state", 32'(st0), 32'(ST_IDLE));
    chk("en_drop.busy", 32'(busy0), 32'd0);
    chk("en_drop.period_holds", 32'(period0), 32'd20);
    cyc(1'b0);
    enable = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    chk("rearm2.valid", 32'(valid0), 32'd0);
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    chk_meas("p4c", 4, 1'b1, 1'b1);
    enable = 1'b0;
    cyc(1'b0);
    chk("en_toggle.in_range_holds", 32'(inr0), 32'd1);
    chk("en_toggle.period_holds", 32'(period0), 32'd4);

    // Tick high through reset release must not look like an edge.
    reset = 1'b1;
    cyc(1'b1);
    cyc(1'b1);
    chk_reset("reset2");
    reset = 1'b0;
    enable = 1'b1;
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b1);
    chk("held_release.state", 32'(st0), 32'(ST_ARMED));
    cyc(1'b0);
    cyc(1'b1);
    chk("held_release.arm_valid", 32'(valid0), 32'd0);
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    chk_meas("p4d", 4, 1'b1, 1'b1);

    // Timeout, rearm, then sys_reset at count 7.
    repeat (20) cyc(1'b0);
    chk("timeout2", 32'(to0), 32'd1);
    cyc(1'b1);
    repeat (6) cyc(1'b0);
    chk("mid.timeout", 32'(to0), 32'd1);
    chk("mid.state", 32'(st0), 32'(ST_MEASURE));
    sys_reset = 1'b1;
    cyc(1'b0);
    chk_reset("sys_reset");
    sys_reset = 1'b0;
    cyc(1'b0);
    chk("post_sysrst.state", 32'(st0), 32'(ST_ARMED));
    cyc(1'b1);
    chk("post_sysrst.arm_valid", 32'(valid0), 32'd0);
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    chk_meas("p4e", 4, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Receive-side companion to the UI clock-enable dividers.
- Watches a one-cycle enable/tick stream, such as a divider's new_clk output.
- Measures the number of clk cycles between consecutive ticks.
- Reports each measured period with a one-cycle valid strobe and an in-tolerance flag.
- Flags a timeout if ticks stop arriving; used to self-check UI timebases at runtime and on the bench.

Parameters:
- W, 25: width of period counter and period output.
- MAX_COUNT, 33554431: timeout threshold in clk cycles; must be ≤ 2^W-1.
- EXPECT, 27000001: nominal period in clk cycles, used for the in_range check.
- TOL, 0: allowed absolute deviation from EXPECT, in clk cycles.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset, input, 1: synchronous active-high reset.
- sys_reset, input, 1: synchronous active-high global reset; ORed with reset, identical effect.
- enable, input, 1: measurement enable; level-sensitive.
- tick, input, 1: synchronous tick input; rising edge = one event.
- period, output, W: last completed period in clk cycles; holds until the next valid.
- period_valid, output, 1: one-cycle strobe, new period available.
- in_range, output, 1: |period-EXPECT| ≤ TOL for the current period; updates with period_valid.
- timeout, output, 1: sticky; set on timeout, cleared by the next period_valid or reset.
- busy, output, 1: high in ARMED and MEASURE states.

Behaviour:
- One clock, clk. reset and sys_reset are synchronous, active-high, and ORed; either one forces the reset state on the next posedge.
- Reset values:
  - state=IDLE, count=0, period=0.
  - period_valid=0, in_range=0, timeout=0, busy=0.
  - tick_d=1, so a tick held high across reset release is not an edge.
- Edge detection:
  - tick_d registers tick every cycle.
  - edge = tick & ~tick_d.
  - A tick held high N cycles counts as one event.
- States:
  - IDLE: count=0.
    - enable=1 → ARMED.
  - ARMED: waits for the first edge.
    - edge → count<=1, go to MEASURE.
    - An edge in ARMED never produces period_valid.
  - MEASURE, evaluated in priority order each cycle:
    - enable=0 → IDLE, count<=0, no valid, even if edge is present this cycle.
    - edge → period<=count, period_valid<=1, in_range<=(|count-EXPECT| ≤ TOL), timeout<=0, count<=1, stay in MEASURE.
    - count==MAX_COUNT, no edge → timeout<=1, count<=0, go to ARMED; no valid.
    - otherwise → count<=count+1.
  - enable=0 in ARMED → IDLE.
- Period semantics:
  - Edges at cycles t0 and t1 give period = t1-t0.
  - A divider with count N (pulse every N+1 cycles) gives period N+1.
- Latency: period, period_valid and in_range are registered and appear the cycle after the edge cycle.
- Boundary cases:
  - Edge on the same cycle count==MAX_COUNT: a valid measurement of MAX_COUNT; edge wins, no timeout.
  - count never wraps; the timeout path guarantees this.
- Arithmetic: the deviation compare uses W+1-bit signed or unsigned-safe subtraction in both directions; no overflow when EXPECT > count.
- Outputs after events:
  - period and in_range hold their values between valids and across enable toggles.
  - Only reset clears period and in_range.
  - timeout persists through IDLE/ARMED until the next valid or reset.
- Reset mid-measurement: abandons the count with no valid; all outputs return to reset values on the next cycle.
- period_valid is never high two consecutive cycles, because the minimum measurable period is 2 (tick pattern 1,0,1).

Test Plan (W=8, MAX_COUNT=20, EXPECT=4, TOL=0):
- enable=1, ticks every 4 cycles (divider N=3) → first tick gives no valid; each later tick gives period=4, period_valid one cycle later, in_range=1, timeout=0.
- Alternate tick intervals 5 and 3 → period=5, in_range=0, then period=3, in_range=0; with TOL=1 both give in_range=1.
- Ticks stop after one period → after 20 cycles without an edge timeout=1, busy=1 (ARMED); next two ticks 4 apart → period=4, timeout clears on that valid.
- tick held high 3 cycles, low 3 cycles, repeating → period=6; the held level counts once. tick high through reset release → no spurious edge.
- Edge exactly at count=20 → period=20 valid, no timeout. Deassert enable on an edge cycle → no valid, state IDLE, busy=0.
- Assert sys_reset mid-MEASURE (count=7) → next cycle period=0, period_valid=0, timeout=0, busy=0; the next measurement needs a fresh arming edge.
